// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-driver signal bundle for uart_tx_arbiter.
// master = requesters + UART driver side, slave = arbiter side.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data;
  logic [3:0]  grant;
  logic [3:0]  byte_ack;
  logic        busy;
  logic        Tx_en;
  logic [7:0]  Tx_Data;
  logic        Tx_ACK;
  logic        timeout_err;

  modport master (
    output req, last, data, Tx_ACK,
    input  grant, byte_ack, busy, Tx_en, Tx_Data, timeout_err
  );

  modport slave (
    input  req, last, data, Tx_ACK,
    output grant, byte_ack, busy, Tx_en, Tx_Data, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters.
// Optional per-byte Tx_ACK timeout enabled by defining UART_ARB_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no owner; round-robin search from ptr each cycle
// SEND     | Tx_en high, waiting for a fresh Tx_ACK rising edge
// WAIT_LOW | byte acknowledged, waiting for Tx_ACK to drop before next byte/release
module uart_tx_arbiter #(
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("MAX_BURST out of range 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] owner, owner_nxt;
  logic [3:0] grant, grant_nxt;
  logic [3:0] byte_ack, byte_ack_nxt;
  logic       tx_en, tx_en_nxt;
  logic [7:0] tx_data, tx_data_nxt;
  logic       last_q, last_nxt;
  logic [7:0] burst, burst_nxt;
  logic       ack_q;
  logic       ack_rise;
  logic       timeout_hit;
  logic [1:0] pick;
  logic       pick_vld;

  assign ack_rise = bus.Tx_ACK & ~ack_q;

  // Walk downward so the requester closest to ptr is assigned last and wins.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[ptr + 2'(i)]) begin
        pick     = ptr + 2'(i);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_err_q;

  assign timeout_hit = (state == SEND) && !ack_rise &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside SEND, so every SEND entry starts a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= timeout_hit;
      if (state != SEND) tmo_cnt <= '0;
      else               tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    grant_nxt    = grant;
    byte_ack_nxt = '0;
    tx_en_nxt    = tx_en;
    tx_data_nxt  = tx_data;
    last_nxt     = last_q;
    burst_nxt    = burst;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt   = SEND;
          owner_nxt   = pick;
          grant_nxt   = 4'b0001 << pick;
          tx_en_nxt   = 1'b1;
          tx_data_nxt = bus.data[{pick, 3'b000} +: 8];
          last_nxt    = bus.last[pick];
        end
      end
      SEND: begin
        if (ack_rise) begin
          state_nxt    = WAIT_LOW;
          tx_en_nxt    = 1'b0;
          byte_ack_nxt = 4'b0001 << owner;
          if (burst != 8'hFF) burst_nxt = burst + 8'd1;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          tx_en_nxt = 1'b0;
          burst_nxt = '0;
          ptr_nxt   = owner + 2'd1;
        end
      end
      WAIT_LOW: begin
        if (!bus.Tx_ACK) begin
          if (bus.req[owner] && !last_q && (burst < MAX_B)) begin
            state_nxt   = SEND;
            tx_en_nxt   = 1'b1;
            tx_data_nxt = bus.data[{owner, 3'b000} +: 8];
            last_nxt    = bus.last[owner];
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            tx_en_nxt = 1'b0;
            burst_nxt = '0;
            ptr_nxt   = owner + 2'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        tx_en_nxt = 1'b0;
        burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      grant    <= '0;
      byte_ack <= '0;
      tx_en    <= 1'b0;
      tx_data  <= '0;
      last_q   <= 1'b0;
      burst    <= '0;
      ack_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      grant    <= grant_nxt;
      byte_ack <= byte_ack_nxt;
      tx_en    <= tx_en_nxt;
      tx_data  <= tx_data_nxt;
      last_q   <= last_nxt;
      burst    <= burst_nxt;
      ack_q    <= bus.Tx_ACK;
    end
  end

  assign bus.grant    = grant;
  assign bus.byte_ack = byte_ack;
  assign bus.busy     = |grant;
  assign bus.Tx_en    = tx_en;
  assign bus.Tx_Data  = tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requesters, a UART driver stand-in and a
// transaction-level model of round-robin/burst rules checked every cycle.
module tb_uart_tx_arbiter;

  localparam int MB  = 5;
  localparam int TMO = 50;

  logic clk;
  logic rst;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.MAX_BURST(MB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rq_d [4][$];
  bit         rq_l [4][$];
  logic [7:0] sd   [4][$];
  bit         sl   [4][$];
  int         e_own[$];
  logic [7:0] e_byte[$];
  int         m_ptr = 0;

  int         grant_log[$];
  int         burst_log[$];
  int         ack_cnt[4];
  logic [3:0] prev_grant = '0;
  bit         chk_en = 1'b0;

  int ack_dly  = 5;
  int ack_w    = 4;
  int ack_mode = 0;   // 0 driver model, 1 force high, 2 force low
  int dcnt     = 0;
  bit dph      = 1'b0;
  int tmo_owner = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input int r, input logic [7:0] b, input bit l);
    rq_d[r].push_back(b);
    rq_l[r].push_back(l);
    sd[r].push_back(b);
    sl[r].push_back(l);
  endtask

  // Expected byte order from the rules alone: round-robin owner choice, then
  // the owner keeps sending until its last flag, queue end or MB bytes.
  task automatic run_model();
    int  o;
    int  n;
    bit  lst;
    while (sd[0].size() + sd[1].size() + sd[2].size() + sd[3].size() > 0) begin
      o = -1;
      for (int k = 0; k < 4; k++)
        if (o < 0 && sd[(m_ptr + k) % 4].size() > 0) o = (m_ptr + k) % 4;
      n = 0;
      do begin
        e_own.push_back(o);
        e_byte.push_back(sd[o].pop_front());
        lst = sl[o].pop_front();
        n++;
      end while (sd[o].size() > 0 && !lst && n < MB);
      m_ptr = (o + 1) % 4;
    end
  endtask

  function automatic bit rq_empty();
    return (rq_d[0].size() + rq_d[1].size() + rq_d[2].size() + rq_d[3].size()) == 0;
  endfunction

  task automatic clear_logs();
    grant_log.delete();
    burst_log.delete();
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
  endtask

  task automatic wait_grant(input int budget);
    int k = 0;
    while (bus.grant == 4'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("grant_seen", 32'(bus.grant != 4'b0), 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!(e_own.size() == 0 && bus.grant == 4'b0 && rq_empty()) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", 32'(k < budget), 1);
    chk("idle_grant", bus.grant, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_tx_en", bus.Tx_en, 0);
  endtask

  // Requesters: present queue heads, pop on acknowledge (or on timeout).
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        if (bus.byte_ack[i] && rq_d[i].size() > 0) begin
          void'(rq_d[i].pop_front());
          void'(rq_l[i].pop_front());
        end
      if (bus.timeout_err && rq_d[tmo_owner].size() > 0) begin
        void'(rq_d[tmo_owner].pop_front());
        void'(rq_l[tmo_owner].pop_front());
      end
      for (int i = 0; i < 4; i++)
        if (bus.grant[i]) tmo_owner = i;
    end
    for (int i = 0; i < 4; i++) begin
      bus.req[i]          = rq_d[i].size() > 0;
      bus.data[8*i +: 8]  = (rq_d[i].size() > 0) ? rq_d[i][0] : 8'h00;
      bus.last[i]         = (rq_d[i].size() > 0) ? rq_l[i][0] : 1'b0;
    end
  end

  // UART driver stand-in: Tx_ACK rises ack_dly cycles into Tx_en, stays ack_w cycles.
  always @(negedge clk) begin
    if (!rst || ack_mode != 0) begin
      dcnt       = 0;
      dph        = 1'b0;
      bus.Tx_ACK = (ack_mode == 1);
    end else if (!dph) begin
      bus.Tx_ACK = 1'b0;
      if (bus.Tx_en) begin
        dcnt++;
        if (dcnt >= ack_dly) begin
          bus.Tx_ACK = 1'b1;
          dph        = 1'b1;
          dcnt       = 0;
        end
      end else begin
        dcnt = 0;
      end
    end else begin
      dcnt++;
      if (dcnt >= ack_w) begin
        bus.Tx_ACK = 1'b0;
        dph        = 1'b0;
        dcnt       = 0;
      end
    end
  end

  // Compare process plus grant/burst logs.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.grant != 4'b0 && prev_grant == 4'b0) begin
        grant_log.push_back(int'(bus.grant));
        burst_log.push_back(0);
      end
      if (bus.byte_ack != 4'b0) begin
        for (int i = 0; i < 4; i++) ack_cnt[i] += int'(bus.byte_ack[i]);
        if (burst_log.size() > 0) burst_log[burst_log.size()-1] += 1;
      end
      prev_grant = bus.grant;
      if (chk_en) begin
        if (bus.Tx_en) begin
          if (e_own.size() == 0) chk("tx_unexpected", 32'(bus.Tx_en), 0);
          else begin
            chk("tx_grant", bus.grant, 32'(1) << e_own[0]);
            chk("tx_data", bus.Tx_Data, e_byte[0]);
            chk("tx_busy", bus.busy, 1);
          end
        end
        if (bus.byte_ack != 4'b0) begin
          if (e_own.size() == 0) chk("ack_unexpected", bus.byte_ack, 0);
          else begin
            chk("ack_owner", bus.byte_ack, 32'(1) << e_own[0]);
            chk("ack_grant", bus.grant, 32'(1) << e_own[0]);
            chk("ack_tx_en_low", bus.Tx_en, 0);
            void'(e_own.pop_front());
            void'(e_byte.pop_front());
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        if (bus.timeout_err) begin
          chk("tmo_grant", bus.grant, 0);
          chk("tmo_no_ack", bus.byte_ack, 0);
          if (e_own.size() > 0) begin
            void'(e_own.pop_front());
            void'(e_byte.pop_front());
          end
        end
`else
        chk("tmo_tied", bus.timeout_err, 0);
`endif
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_byte_ack", bus.byte_ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_en", bus.Tx_en, 0);
    chk("rst_tx_data", bus.Tx_Data, 0);
    chk("rst_tmo", bus.timeout_err, 0);
    @(posedge clk); #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    // Round-robin: all four request, requester 0 has a second one-byte packet.
    @(posedge clk); #1;
    clear_logs();
    add(0, 8'h10, 1); add(0, 8'h14, 1);
    add(1, 8'h11, 1); add(2, 8'h12, 1); add(3, 8'h13, 1);
    run_model();
    wait_done(400);
    chk("rr_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      chk("rr_g0", grant_log[0], 1);
      chk("rr_g1", grant_log[1], 2);
      chk("rr_g2", grant_log[2], 4);
      chk("rr_g3", grant_log[3], 8);
      chk("rr_g4", grant_log[4], 1);
    end

    // Single byte with a 100-cycle driver response.
`ifdef UART_ARB_TIMEOUT_EN
    ack_dly = 40;
`else
    ack_dly = 100;
`endif
    @(posedge clk); #1;
    clear_logs();
    add(0, 8'h55, 1);
    run_model();
    @(negedge clk);
    chk("sb_grant_n", bus.grant, 0);
    @(negedge clk);
    chk("sb_grant_n1", bus.grant, 4'b0001);
    chk("sb_tx_en_n1", bus.Tx_en, 1);
    chk("sb_tx_data_n1", bus.Tx_Data, 8'h55);
    wait_done(400);
    chk("sb_acks", ack_cnt[0], 1);
    ack_dly = 5;

    // Burst of four bytes from requester 2, last on 0xA3.
    @(posedge clk); #1;
    clear_logs();
    add(2, 8'hA0, 0); add(2, 8'hA1, 0); add(2, 8'hA2, 0); add(2, 8'hA3, 1);
    run_model();
    wait_done(400);
    chk("burst_acks", ack_cnt[2], 4);
    chk("burst_grants", grant_log.size(), 1);
    if (grant_log.size() == 1) chk("burst_owner", grant_log[0], 4);

    // MAX_BURST split: two requesters, seven bytes each, last never set.
    @(posedge clk); #1;
    clear_logs();
    for (int b = 0; b < 7; b++) begin
      add(0, 8'hB0 + 8'(b), 0);
      add(1, 8'hC0 + 8'(b), 0);
    end
    run_model();
    wait_done(800);
    chk("mb_grants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("mb_g0", grant_log[0], 1);
      chk("mb_g1", grant_log[1], 2);
      chk("mb_g2", grant_log[2], 1);
      chk("mb_g3", grant_log[3], 2);
      chk("mb_n0", burst_log[0], 5);
      chk("mb_n1", burst_log[1], 5);
      chk("mb_n2", burst_log[2], 2);
      chk("mb_n3", burst_log[3], 2);
    end

    // Tx_ACK already high when SEND is entered: must wait for a fresh edge.
    ack_mode = 1;
    @(posedge clk); #1;
    clear_logs();
    add(3, 8'h3C, 1);
    run_model();
    wait_grant(10);
    repeat (20) @(negedge clk);
    chk("hi_tx_en_held", bus.Tx_en, 1);
    chk("hi_no_ack", ack_cnt[3], 0);
    ack_mode = 0;
    wait_done(200);
    chk("hi_acks", ack_cnt[3], 1);

`ifdef UART_ARB_TIMEOUT_EN
    begin
      int k;
      ack_mode = 2;
      @(posedge clk); #1;
      clear_logs();
      add(1, 8'h77, 1);
      run_model();
      wait_grant(10);
      k = 0;
      while (!bus.timeout_err && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("tmo_latency", k, TMO);
      chk("tmo_grant_lit", bus.grant, 0);
      ack_mode = 0;
      wait_done(200);
      chk("tmo_acks", ack_cnt[1], 0);
    end
`endif

    // Reset in the middle of a byte, then a fresh request from requester 1.
    ack_mode = 2;
    @(posedge clk); #1;
    clear_logs();
    add(2, 8'h99, 1);
    run_model();
    wait_grant(10);
    repeat (3) @(negedge clk);
    #2;
    chk_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_byte_ack", bus.byte_ack, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_tx_en", bus.Tx_en, 0);
    chk("mid_rst_tx_data", bus.Tx_Data, 0);
    chk("mid_rst_tmo", bus.timeout_err, 0);
    for (int i = 0; i < 4; i++) begin
      rq_d[i].delete();
      rq_l[i].delete();
    end
    e_own.delete();
    e_byte.delete();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst      = 1'b1;
    ack_mode = 0;
    add(1, 8'h11, 1);
    run_model();
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_grant", bus.grant, 4'b0010);
    wait_done(200);
    chk("post_rst_abandoned", ack_cnt[2], 0);
    chk("post_rst_acks", ack_cnt[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
